// File: rtl/hvac_actuator_ctrl.sv
// rtl/hvac_actuator_ctrl.sv - heater/compressor/fan actuator sequencer with min-on, anti-short-cycle lockout and fan run-on (optional: HVAC_FAN_RUNON_EN)
module hvac_actuator_ctrl #(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 6,
  parameter int RUNON   = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heating_req,
  input  logic       cooling_req,
  output logic       heater_on,
  output logic       compressor_on,
  output logic       fan_on,
  output logic [1:0] state,
  output logic       cool_wait,
  output logic       fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HEAT  = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;
  localparam logic [1:0] S_RUNON = 2'd3;

  // Timers count down to zero, so each load value is the duration minus one.
  localparam logic [CNT_W-1:0] MIN_ON_LD  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LD = CNT_W'(MIN_OFF - 1);
`ifdef HVAC_FAN_RUNON_EN
  localparam logic [CNT_W-1:0] RUNON_LD   = CNT_W'(RUNON - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  // Reject timer settings that cannot be represented or would give a zero duration.
  generate
    if (MIN_ON < 1 || MIN_OFF < 1 || RUNON < 1 ||
        MIN_ON >= (2 ** CNT_W) || MIN_OFF >= (2 ** CNT_W) || RUNON >= (2 ** CNT_W)) begin : g_bad_params
      $error("hvac_actuator_ctrl: timer parameter out of range");
    end
  endgenerate

  logic [CNT_W-1:0] run_tmr;
  logic [CNT_W-1:0] lock_tmr;
  logic [CNT_W-1:0] run_nxt;
  logic [CNT_W-1:0] lock_nxt;
  logic [1:0]       state_nxt;
  logic             cool_wait_nxt;
  logic             conflict;
  logic             load_req;

  assign conflict = heating_req & cooling_req;

  // Next-state, timer and cool_wait decisions from the sampled request levels.
  always_comb begin
    state_nxt     = state;
    run_nxt       = run_tmr;
    lock_nxt      = (lock_tmr != CNT_ZERO) ? (lock_tmr - CNT_ONE) : lock_tmr;
    cool_wait_nxt = 1'b0;
    load_req      = (state == S_HEAT) ? heating_req : cooling_req;

    case (state)
      S_IDLE: begin
        if (!conflict) begin
          if (heating_req) begin
            state_nxt = S_HEAT;
            run_nxt   = MIN_ON_LD;
          end else if (cooling_req) begin
            if (lock_tmr == CNT_ZERO) begin
              state_nxt = S_COOL;
              run_nxt   = MIN_ON_LD;
            end else begin
              cool_wait_nxt = 1'b1;
            end
          end
        end
      end

      S_HEAT, S_COOL: begin
        if (run_tmr == CNT_ZERO && (!load_req || conflict)) begin
          // Compressor just stopped: arm the anti-short-cycle lockout.
          if (state == S_COOL) begin
            lock_nxt = MIN_OFF_LD;
          end
`ifdef HVAC_FAN_RUNON_EN
          state_nxt = S_RUNON;
          run_nxt   = RUNON_LD;
`else
          state_nxt = S_IDLE;
`endif
        end else if (run_tmr != CNT_ZERO) begin
          run_nxt = run_tmr - CNT_ONE;
        end
      end

      S_RUNON: begin
`ifdef HVAC_FAN_RUNON_EN
        if (run_tmr == CNT_ZERO) begin
          state_nxt = S_IDLE;
        end else begin
          run_nxt = run_tmr - CNT_ONE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State, timers and Moore-decoded drives all update together on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      run_tmr       <= CNT_ZERO;
      lock_tmr      <= CNT_ZERO;
      heater_on     <= 1'b0;
      compressor_on <= 1'b0;
      fan_on        <= 1'b0;
      cool_wait     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      run_tmr       <= run_nxt;
      lock_tmr      <= lock_nxt;
      heater_on     <= (state_nxt == S_HEAT);
      compressor_on <= (state_nxt == S_COOL);
      fan_on        <= (state_nxt != S_IDLE);
      cool_wait     <= cool_wait_nxt;
      fault         <= conflict;
    end
  end

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// tb/tb_hvac_actuator_ctrl.sv - self-checking bench for hvac_actuator_ctrl (expectations follow HVAC_FAN_RUNON_EN)
module tb_hvac_actuator_ctrl;

  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 6;
  localparam int RUNON   = 4;
`ifdef HVAC_FAN_RUNON_EN
  localparam int FAN_EN = 1;
`else
  localparam int FAN_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       heating_req;
  logic       cooling_req;
  logic       heater_on;
  logic       compressor_on;
  logic       fan_on;
  logic [1:0] state;
  logic       cool_wait;
  logic       fault;

  always #5 clk = ~clk;

  hvac_actuator_ctrl #(
    .MIN_ON (MIN_ON),
    .MIN_OFF(MIN_OFF),
    .RUNON  (RUNON),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .heating_req  (heating_req),
    .cooling_req  (cooling_req),
    .heater_on    (heater_on),
    .compressor_on(compressor_on),
    .fan_on       (fan_on),
    .state        (state),
    .cool_wait    (cool_wait),
    .fault        (fault)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_state3 = 0;

  // Reference model in observable terms: which load runs, how long it has
  // been running (counting up), and how long the compressor has been off.
  int m_mode;
  int m_cnt;
  int m_off;
  bit m_fault;
  bit m_cw;

  typedef struct {
    bit r;
    bit hr;
    bit cr;
    bit heat;
    bit comp;
    bit fan;
    int st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit h, input bit c);
    int old;
    bit req;
    if (!r) begin
      m_mode = 0; m_cnt = 0; m_off = 1000; m_fault = 0; m_cw = 0;
      return;
    end
    old = m_mode;
    m_fault = h & c;
    m_cw = 0;
    req = (old == 1) ? h : c;
    case (old)
      0: if (!(h && c)) begin
           if (h) begin
             m_mode = 1; m_cnt = 1;
           end else if (c) begin
             if (m_off >= MIN_OFF) begin
               m_mode = 2; m_cnt = 1;
             end else begin
               m_cw = 1;
             end
           end
         end
      1, 2: begin
        if (m_cnt >= MIN_ON && (!req || (h && c))) begin
          m_mode = (FAN_EN != 0) ? 3 : 0;
          m_cnt = 1;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        if (m_cnt >= RUNON) m_mode = 0;
        else m_cnt++;
      end
    endcase
    if (m_mode == 2) m_off = 0;
    else if (m_off < 1000) m_off++;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit r, input bit h, input bit c);
    rst_n = r;
    heating_req = h;
    cooling_req = c;
    @(posedge clk);
    model_edge(r, h, c);
    #1;
    check("model heater_on", heater_on, (m_mode == 1));
    check("model compressor_on", compressor_on, (m_mode == 2));
    check("model fan_on", fan_on, (m_mode != 0));
    check("model state", state, m_mode);
    check("model cool_wait", cool_wait, m_cw);
    check("model fault", fault, m_fault);
    check("interlock heater&compressor", heater_on & compressor_on, 0);
    if (state == 2'd3) n_state3++;
  endtask

  function automatic void add(input bit r, input bit hr, input bit cr,
                              input bit heat, input bit comp, input bit fan, input int st);
    vec_t v;
    v.r = r; v.hr = hr; v.cr = cr; v.heat = heat; v.comp = comp; v.fan = fan; v.st = st;
    vecs.push_back(v);
  endfunction

  initial begin
    int hi;
    int lo;
    int cwn;
    int exp_cw;
    int runon_win;
    int direct;
    int saw_idle;
    bit done;
    bit h;
    bit c;
    logic [1:0] prev;

    rst_n = 1'b0;
    heating_req = 1'b0;
    cooling_req = 1'b0;

    // Reset dominance followed by a one-cycle heating pulse (min-on, run-on).
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < MIN_ON - 1; i++) add(1, 0, 0, 1, 0, 1, 1);
    if (FAN_EN != 0)
      for (int i = 0; i < RUNON; i++) add(1, 0, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].hr, vecs[i].cr);
      check($sformatf("vec%0d heater_on", i), heater_on, vecs[i].heat);
      check($sformatf("vec%0d compressor_on", i), compressor_on, vecs[i].comp);
      check($sformatf("vec%0d fan_on", i), fan_on, vecs[i].fan);
      check($sformatf("vec%0d state", i), state, vecs[i].st);
    end

    // Short-cycle lockout: 10 cycles cooling, one-cycle drop, immediate re-request.
    step(0, 0, 0);
    step(1, 0, 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1);
      hi += compressor_on;
    end
    step(1, 0, 0);
    lo = compressor_on ? 0 : 1;
    cwn = cool_wait;
    done = 0;
    for (int k = 0; k < 40; k++) begin
      if (!done) begin
        step(1, 0, 1);
        if (compressor_on) done = 1;
        else begin
          lo++;
          cwn += cool_wait;
        end
      end
    end
    exp_cw = (FAN_EN != 0) ? (MIN_OFF - RUNON - 1) : (MIN_OFF - 1);
    check("lockout compressor restarts", done, 1);
    check("lockout high cycles", hi, 10);
    check("lockout low cycles", lo, MIN_OFF);
    check("lockout cool_wait cycles", cwn, exp_cw);

    // Conflict in IDLE, then conflict during COOL after its minimum on-time.
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 1);
    check("conflict idle fault", fault, 1);
    check("conflict idle drives", heater_on | compressor_on | fan_on, 0);
    check("conflict idle state", state, 0);
    for (int i = 0; i < MIN_ON; i++) step(1, 0, 1);
    check("conflict cool running", compressor_on, 1);
    step(1, 1, 1);
    check("conflict cool exits", compressor_on, 0);
    check("conflict cool fault", fault, 1);
    step(1, 0, 0);
    check("conflict fault clears", fault, 0);

    // Changeover from heating to cooling must pass through run-on/idle.
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    prev = state;
    direct = 0;
    saw_idle = 0;
    runon_win = 0;
    done = 0;
    for (int k = 0; k < 60; k++) begin
      if (!done) begin
        step(1, 0, 1);
        if (prev == 2'd1 && state == 2'd2) direct++;
        if (state == 2'd0) saw_idle = 1;
        if (state == 2'd3) runon_win++;
        if (state == 2'd2) done = 1;
        prev = state;
      end
    end
    check("changeover reaches COOL", done, 1);
    check("changeover no direct HEAT->COOL", direct, 0);
    check("changeover passes IDLE", saw_idle, 1);
    check("changeover runon cycles", runon_win, FAN_EN * RUNON);

    // Randomized sticky request levels with rare resets.
    h = 0;
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      if ($urandom_range(0, 7) == 0) c = ~c;
      step(($urandom_range(0, 299) != 0), h, c);
    end

    check("runon state observed", (n_state3 > 0) ? 1 : 0, FAN_EN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
